wb_sdram_arbiter: RTL and testbench
===================================

// Module: wb_sdram_arbiter
// PURPOSE
//  Two-master Wishbone (classic, pipelined-off) arbiter in front of the single SDRAM
//  controller slave port. Lets the on-board test master (switch/hex path) and the UART
//  loader share SDRAM. Round-robin on contention, ownership held for a whole cyc
//  (bursts stay atomic). Bus watchdog aborts a hung slave with err.
// PARAMETERS
//  ADDR_W   32    Wishbone address width (byte address)
//  DATA_W   32    data width; SEL_W = DATA_W/8 derived, not overridable
//  TIMEOUT  1023  cycles stb may stay unacknowledged before abort; must be >= 2
// PORTS
//  clock         in   1       single clock domain
//  reset         in   1       synchronous, active-high
//  io_mN_cyc     in   1       master N (N=0,1) cycle request
//  io_mN_stb     in   1       master N strobe
//  io_mN_we      in   1       master N write enable
//  io_mN_adr     in   ADDR_W  master N address
//  io_mN_dat_w   in   DATA_W  master N write data
//  io_mN_sel     in   SEL_W   master N byte selects
//  io_mN_ack     out  1       ack routed to master N (owner only)
//  io_mN_err     out  1       err routed to master N (owner only; slave err or timeout)
//  io_mN_dat_r   out  DATA_W  read data (broadcast of io_s_dat_r)
//  io_s_cyc/stb/we/adr/dat_w/sel  out  as above   muxed to slave
//  io_s_ack      in   1       slave ack
//  io_s_err      in   1       slave err
//  io_s_dat_r    in   DATA_W  slave read data
//  io_grant      out  2       one-hot current owner (bit N = master N), 00 idle
//  io_timeout    out  1       1-cycle pulse when watchdog fires
// BEHAVIOUR
//  - State: IDLE, OWN0, OWN1 (registered); last_owner bit; watchdog counter.
//  - Reset: state IDLE, last_owner=1 (m0 wins first tie), counter 0, io_grant=00,
//    io_timeout=0, all ack/err 0, all io_s_* outputs 0.
//  - IDLE: if exactly one cyc high -> OWN of that master; both high -> master != last_owner.
//    Decision registered: cyc seen in cycle N -> io_grant and io_s_cyc valid in N+1.
//  - io_s_* = owner's inputs combinationally from registered state; IDLE drives all zero.
//  - OWNx: held while io_mx_cyc=1. When io_mx_cyc=0: next state chosen by IDLE rules
//    but with other master preferred (direct OWN0->OWN1 handoff, no idle bubble);
//    last_owner<=x. Slave cyc drops in the same cycle as owner cyc (mux follows input).
//  - ack/err: io_s_ack/io_s_err gated to owner only; non-owner sees 0. Ack/err arriving
//    while IDLE or after owner released is discarded.
//  - Watchdog: counter clears on any cycle with !io_s_stb or io_s_ack or io_s_err;
//    else increments. When counter==TIMEOUT-1 and no ack/err that cycle: owner gets
//    err=1 for one cycle, io_timeout=1, io_s_cyc/stb forced 0 that cycle, counter->0.
//    Ownership retained (master decides whether to drop cyc). Ack same cycle wins.
//  - Reset mid-transfer: next cycle state IDLE, slave sees cyc=0; in-flight ack dropped.
//  - No combinational path from io_s_ack to io_s_cyc/stb other than the watchdog force.
// STRUCTURE
//  - Package wb_arb_pkg: arb_state_t enum {IDLE,OWN0,OWN1}, owner_t, grant one-hot consts.
//  - One sub-module: wb_watchdog (parameter TIMEOUT; inputs stb/ack/err, output fire).
//  - Top: FSM + output mux; no other hierarchy.
// TESTING
//  - Single m0 read adr=0x100, slave acks 2 cycles later dat=0xDEADBEEF -> io_grant=01
//    cycle after cyc, m0 ack=1 with 0xDEADBEEF, m1 ack=0 throughout.
//  - m0 and m1 assert cyc same cycle after reset -> m0 granted; m0 drops cyc ->
//    io_grant 01->10 next cycle with no 00 gap; next tie -> m0 again.
//  - m1 4-beat write burst (cyc held, stb per beat) while m0 requests -> all 4 beats to
//    slave with m1 adr/data, m0 granted only after m1 cyc falls.
//  - TIMEOUT=8, slave never acks -> after 8 stb cycles owner err=1 and io_timeout=1 for
//    exactly 1 cycle, io_s_stb=0 that cycle; ack on cycle 8 instead -> ack, no err.
//  - reset asserted during OWN1 with stb pending -> next cycle io_grant=00, io_s_cyc=0,
//    late io_s_ack produces no ack on either master.
//  - slave err with m0 owner -> m0 err=1, m1 err=0, io_timeout=0, counter cleared.

Source files
------------

// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared types for the two-master SDRAM Wishbone arbiter.
// Pure declarations: no latency or backpressure of its own.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Identifies a master: 0 = test master, 1 = UART loader.
  typedef logic owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Owner selection from the cyc requests; 'prefer' breaks a tie.
  function automatic arb_state_t pick_owner(input logic c0, input logic c1, input owner_t prefer);
    if (c0 && c1) return prefer ? OWN1 : OWN0;
    if (c0)       return OWN0;
    if (c1)       return OWN1;
    return IDLE;
  endfunction

endpackage

// File: rtl/wb_sdram_arbiter_if.sv
// Classic Wishbone bus bundle; master modport drives the request, slave modport answers.
// No storage: latency and backpressure are those of the attached endpoints.
interface wb_sdram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [SEL_W-1:0]  sel;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel, input  ack, err, dat_r);
  modport slave  (input  cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);
endinterface

// File: rtl/wb_sdram_arbiter_watchdog.sv
// Bus watchdog: fires for one cycle once stb has waited TIMEOUT cycles unanswered.
// Fire is combinational in the expiring cycle; an ack or err in that same cycle wins.
module wb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic fire
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign fire = stb && !ack && !err && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (!stb || ack || err || fire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter for the SDRAM port; ownership is held for a whole cyc.
// Grant registered one cycle after cyc; slave stall stretches the owner, watchdog aborts with err.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  wb_sdram_arbiter_if.slave     io_m0,
  wb_sdram_arbiter_if.slave     io_m1,
  wb_sdram_arbiter_if.master    io_s,
  output logic [1:0]            io_grant,
  output logic                  io_timeout
);
  localparam int SEL_W = DATA_W / 8;

  arb_state_t state, state_nxt;
  owner_t     last_owner, last_owner_nxt;

  logic              s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_w;
  logic [SEL_W-1:0]  s_sel;
  logic              fire;
  logic              own0_live, own1_live;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // On release the other master is preferred, giving a direct handoff with no idle bubble.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: state_nxt = pick_owner(io_m0.cyc, io_m1.cyc, ~last_owner);
      OWN0: if (!io_m0.cyc) begin
        state_nxt      = pick_owner(1'b0, io_m1.cyc, 1'b1);
        last_owner_nxt = 1'b0;
      end
      OWN1: if (!io_m1.cyc) begin
        state_nxt      = pick_owner(io_m0.cyc, 1'b0, 1'b0);
        last_owner_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    io_grant = GRANT_NONE;
    case (state)
      OWN0: begin
        s_cyc = io_m0.cyc; s_stb = io_m0.stb; s_we = io_m0.we;
        s_adr = io_m0.adr; s_dat_w = io_m0.dat_w; s_sel = io_m0.sel;
        io_grant = GRANT_M0;
      end
      OWN1: begin
        s_cyc = io_m1.cyc; s_stb = io_m1.stb; s_we = io_m1.we;
        s_adr = io_m1.adr; s_dat_w = io_m1.dat_w; s_sel = io_m1.sel;
        io_grant = GRANT_M1;
      end
      default: ;
    endcase
  end

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock (clock),
    .reset (reset),
    .stb   (s_cyc & s_stb),
    .ack   (io_s.ack),
    .err   (io_s.err),
    .fire  (fire)
  );

  // The abort cycle drops cyc/stb so the slave sees the transfer end.
  assign io_s.cyc   = s_cyc & ~fire;
  assign io_s.stb   = s_stb & ~fire;
  assign io_s.we    = s_we;
  assign io_s.adr   = s_adr;
  assign io_s.dat_w = s_dat_w;
  assign io_s.sel   = s_sel;

  assign own0_live = (state == OWN0) && io_m0.cyc;
  assign own1_live = (state == OWN1) && io_m1.cyc;

  assign io_m0.ack   = own0_live & io_s.ack;
  assign io_m0.err   = own0_live & (io_s.err | fire);
  assign io_m0.dat_r = io_s.dat_r;
  assign io_m1.ack   = own1_live & io_s.ack;
  assign io_m1.err   = own1_live & (io_s.err | fire);
  assign io_m1.dat_r = io_s.dat_r;

  assign io_timeout = fire;
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter with TIMEOUT=8: grant timing, round-robin, bursts, watchdog, reset.
module tb_wb_sdram_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] io_grant;
  logic       io_timeout;
  int         npass  = 0;
  int         ntotal = 0;

  wb_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
  wb_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
  wb_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s ();

  wb_sdram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_m0      (m0),
    .io_m1      (m1),
    .io_s       (s),
    .io_grant   (io_grant),
    .io_timeout (io_timeout)
  );

  always #5 clock = ~clock;

  task automatic clk_step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drv_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m0.cyc = cyc; m0.stb = stb; m0.we = we; m0.adr = adr; m0.dat_w = dat; m0.sel = 4'hf;
  endtask

  task automatic drv_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat);
    m1.cyc = cyc; m1.stb = stb; m1.we = we; m1.adr = adr; m1.dat_w = dat; m1.sel = 4'hf;
  endtask

  initial begin
    reset = 1'b1;
    drv_m0(0, 0, 0, 0, 0);
    drv_m1(0, 0, 0, 0, 0);
    s.ack = 1'b0; s.err = 1'b0; s.dat_r = '0;

    // Reset state
    repeat (2) clk_step();
    settle();
    chk("rst_grant", 32'(io_grant), 32'h0);
    chk("rst_timeout", 32'(io_timeout), 32'h0);
    chk("rst_s_cyc", 32'(s.cyc), 32'h0);
    chk("rst_s_stb", 32'(s.stb), 32'h0);
    chk("rst_s_adr", s.adr, 32'h0);
    chk("rst_m0_ack", 32'(m0.ack), 32'h0);
    clk_step(); reset = 1'b0;

    // Single m0 read, slave acks two cycles after cyc
    clk_step(); drv_m0(1, 1, 0, 32'h100, 0); settle();
    chk("rd_grant_pre", 32'(io_grant), 32'h0);
    chk("rd_s_cyc_pre", 32'(s.cyc), 32'h0);
    clk_step(); settle();
    chk("rd_grant", 32'(io_grant), 32'h1);
    chk("rd_s_cyc", 32'(s.cyc), 32'h1);
    chk("rd_s_adr", s.adr, 32'h100);
    chk("rd_m0_ack_wait", 32'(m0.ack), 32'h0);
    chk("rd_m1_ack_wait", 32'(m1.ack), 32'h0);
    clk_step(); s.ack = 1'b1; s.dat_r = 32'hDEADBEEF; settle();
    chk("rd_m0_ack", 32'(m0.ack), 32'h1);
    chk("rd_m0_dat", m0.dat_r, 32'hDEADBEEF);
    chk("rd_m1_ack", 32'(m1.ack), 32'h0);
    clk_step(); s.ack = 1'b0; drv_m0(0, 0, 0, 0, 0); settle();
    chk("rd_rel_grant", 32'(io_grant), 32'h1);
    chk("rd_rel_s_cyc", 32'(s.cyc), 32'h0);
    clk_step(); settle();
    chk("rd_idle_grant", 32'(io_grant), 32'h0);

    // Tie after reset: m0 first, direct handoff to m1, next tie back to m0
    clk_step(); reset = 1'b1;
    clk_step(); reset = 1'b0;
    clk_step(); drv_m0(1, 1, 0, 32'h10, 0); drv_m1(1, 1, 0, 32'h20, 0); settle();
    clk_step(); settle();
    chk("tie_grant_m0", 32'(io_grant), 32'h1);
    chk("tie_s_adr_m0", s.adr, 32'h10);
    clk_step(); drv_m0(0, 0, 0, 0, 0); settle();
    chk("tie_rel_grant", 32'(io_grant), 32'h1);
    clk_step(); settle();
    chk("handoff_grant", 32'(io_grant), 32'h2);
    chk("handoff_s_adr", s.adr, 32'h20);
    clk_step(); drv_m1(0, 0, 0, 0, 0); settle();
    clk_step(); drv_m0(1, 1, 0, 32'h10, 0); drv_m1(1, 1, 0, 32'h20, 0); settle();
    chk("tie2_idle", 32'(io_grant), 32'h0);
    clk_step(); settle();
    chk("tie2_grant_m0", 32'(io_grant), 32'h1);
    clk_step(); drv_m0(0, 0, 0, 0, 0); drv_m1(0, 0, 0, 0, 0);
    clk_step(); settle();
    chk("tie2_idle_after", 32'(io_grant), 32'h0);

    // m1 4-beat write burst while m0 waits
    clk_step(); drv_m1(1, 0, 1, 0, 0); settle();
    for (int i = 0; i < 4; i++) begin
      clk_step();
      drv_m1(1, 1, 1, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i));
      drv_m0(1, 1, 0, 32'h300, 0);
      s.ack = 1'b1;
      settle();
      chk("burst_grant", 32'(io_grant), 32'h2);
      chk("burst_s_adr", s.adr, 32'h200 + 32'(4 * i));
      chk("burst_s_dat", s.dat_w, 32'hA000 + 32'(i));
      chk("burst_s_we", 32'(s.we), 32'h1);
      chk("burst_m1_ack", 32'(m1.ack), 32'h1);
      chk("burst_m0_ack", 32'(m0.ack), 32'h0);
    end
    clk_step(); drv_m1(0, 0, 0, 0, 0); s.ack = 1'b0; settle();
    chk("burst_end_grant", 32'(io_grant), 32'h2);
    chk("burst_end_s_cyc", 32'(s.cyc), 32'h0);
    clk_step(); settle();
    chk("burst_m0_grant", 32'(io_grant), 32'h1);
    chk("burst_m0_adr", s.adr, 32'h300);
    clk_step(); drv_m0(0, 0, 0, 0, 0);
    clk_step();

    // Watchdog: 8th unanswered stb cycle aborts; later an ack in the 8th cycle wins
    clk_step(); drv_m0(1, 1, 0, 32'h400, 0); settle();
    for (int k = 1; k <= 7; k++) begin
      clk_step(); settle();
      chk("wd_pre_err", 32'(m0.err), 32'h0);
      chk("wd_pre_to", 32'(io_timeout), 32'h0);
    end
    clk_step(); settle();
    chk("wd_fire_err", 32'(m0.err), 32'h1);
    chk("wd_fire_to", 32'(io_timeout), 32'h1);
    chk("wd_fire_s_stb", 32'(s.stb), 32'h0);
    chk("wd_fire_s_cyc", 32'(s.cyc), 32'h0);
    chk("wd_fire_m1_err", 32'(m1.err), 32'h0);
    clk_step(); settle();
    chk("wd_after_to", 32'(io_timeout), 32'h0);
    chk("wd_after_err", 32'(m0.err), 32'h0);
    chk("wd_after_s_stb", 32'(s.stb), 32'h1);
    chk("wd_after_grant", 32'(io_grant), 32'h1);
    repeat (6) clk_step();
    clk_step(); s.ack = 1'b1; settle();
    chk("wd_ack_wins_ack", 32'(m0.ack), 32'h1);
    chk("wd_ack_wins_err", 32'(m0.err), 32'h0);
    chk("wd_ack_wins_to", 32'(io_timeout), 32'h0);
    clk_step(); s.ack = 1'b0; drv_m0(0, 0, 0, 0, 0);
    clk_step();

    // Reset during OWN1 with stb pending, late ack discarded
    clk_step(); drv_m1(1, 1, 0, 32'h500, 0); settle();
    clk_step(); settle();
    chk("rstmid_grant_own", 32'(io_grant), 32'h2);
    clk_step(); reset = 1'b1; settle();
    clk_step(); reset = 1'b0; s.ack = 1'b1; settle();
    chk("rstmid_grant", 32'(io_grant), 32'h0);
    chk("rstmid_s_cyc", 32'(s.cyc), 32'h0);
    chk("rstmid_m1_ack", 32'(m1.ack), 32'h0);
    chk("rstmid_m0_ack", 32'(m0.ack), 32'h0);
    clk_step(); s.ack = 1'b0; drv_m1(0, 0, 0, 0, 0);
    clk_step();

    // Slave err to owner m0 clears the watchdog
    clk_step(); drv_m0(1, 1, 0, 32'h600, 0); settle();
    repeat (3) clk_step();
    clk_step(); s.err = 1'b1; settle();
    chk("serr_m0_err", 32'(m0.err), 32'h1);
    chk("serr_m1_err", 32'(m1.err), 32'h0);
    chk("serr_to", 32'(io_timeout), 32'h0);
    chk("serr_m0_ack", 32'(m0.ack), 32'h0);
    clk_step(); s.err = 1'b0;
    repeat (5) clk_step();
    clk_step(); settle();
    chk("serr_cnt_7th", 32'(io_timeout), 32'h0);
    clk_step(); settle();
    chk("serr_cnt_8th", 32'(io_timeout), 32'h1);
    chk("serr_cnt_8th_err", 32'(m0.err), 32'h1);
    clk_step(); drv_m0(0, 0, 0, 0, 0);
    clk_step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
